pds_arb: RTL and testbench

PDS bus arbiter for the accelerator CPLD. It runs the 68000 bus-request handshake (`nBR_IOB` / `nBG_IOB` / `nBGACK_IOB`) against the logic-board CPU and waits for the PDS bus to go idle. It then grants address/strobe drive to the IOB master controller through `AoutOE`, and hands the bus back on request without cutting off an IOB cycle in flight. It sits between the PDS pins and the IOB master controller, which consumes `AoutOE` and `Owned`.

---
 rtl/warpse_pkg.sv | 16 +
 rtl/pds_arb_sync2.sv | 22 ++
 rtl/pds_arb.sv | 151 +++++++++++++++
 tb/tb_pds_arb.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/warpse_pkg.sv
// Shared definitions for the accelerator CPLD: PDS arbiter state encoding
// and default arbitration constants.
package warpse_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAITIDLE = 3'd2,
    OWN      = 3'd3,
    REL      = 3'd4
  } arb_state_t;

  localparam int unsigned ARB_IDLE_CYCLES    = 3;
  localparam int unsigned ARB_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/pds_arb_sync2.sv
// Two-flop synchronizer for asynchronous PDS pin readbacks; resets to the
// inactive (high) level so active-low pins read as deasserted out of reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pds_arb.sv
// PDS bus arbiter: 68000 BR/BG/BGACK handshake, idle-bus qualification and
// release sequencing. Optional grant timeout flag under PDS_ARB_TIMEOUT_EN.
module pds_arb
  import warpse_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES    = ARB_IDLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES,
  parameter int unsigned CNTW           = 12
) (
  input  logic CLK,
  input  logic nRES,
  input  logic nBG_IOB,
  input  logic nAS_IOBin,
  input  logic nBGACKin,
  input  logic RelReq,
  input  logic Busy,
  output logic nBR_IOB,
  output logic nBGACK_IOB,
  output logic AoutOE,
  output logic Owned,
  output logic ArbFail
);

`ifdef PDS_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNTW-1:0] IDLE_MATCH    = CNTW'(IDLE_CYCLES);
  localparam logic [CNTW-1:0] TIMEOUT_MATCH = CNTW'(TIMEOUT_CYCLES - 1);

  logic bg_s, as_s, bgack_s;

  sync2 u_sync_bg    (.clk(CLK), .rst_n(nRES), .d(nBG_IOB),   .q(bg_s));
  sync2 u_sync_as    (.clk(CLK), .rst_n(nRES), .d(nAS_IOBin), .q(as_s));
  sync2 u_sync_bgack (.clk(CLK), .rst_n(nRES), .d(nBGACKin),  .q(bgack_s));

  arb_state_t      state, state_d;
  logic [CNTW-1:0] cnt, cnt_d;
  logic            nbr, nbr_d;
  logic            nbgack, nbgack_d;
  logic            aout, aout_d;
  logic            owned;
  logic            fail, fail_d;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    nbr_d    = nbr;
    nbgack_d = nbgack;
    aout_d   = aout;
    fail_d   = fail;
    case (state)
      IDLE: begin
        nbr_d = 1'b1;
        cnt_d = '0;
        if (!RelReq) begin
          state_d = REQ;
          nbr_d   = 1'b0;
        end
      end
      REQ: begin
        nbr_d = 1'b0;
        if (cnt != '1) cnt_d = cnt + CNTW'(1);
        if (TIMEOUT_EN && (cnt >= TIMEOUT_MATCH)) fail_d = 1'b1;
        // Release outranks a grant arriving in the same cycle.
        if (RelReq) begin
          state_d = IDLE;
          nbr_d   = 1'b1;
          cnt_d   = '0;
        end else if (!bg_s) begin
          state_d = WAITIDLE;
          cnt_d   = '0;
        end
      end
      WAITIDLE: begin
        nbr_d = 1'b0;
        // Grant withdrawal outranks completion of the idle count.
        if (bg_s) begin
          state_d = REQ;
          cnt_d   = '0;
        end else if (cnt == IDLE_MATCH) begin
          state_d  = OWN;
          nbgack_d = 1'b0;
          cnt_d    = '0;
        end else if (as_s && bgack_s) begin
          cnt_d = cnt + CNTW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      OWN: begin
        nbgack_d = 1'b0;
        nbr_d    = 1'b1;
        if (RelReq && !Busy) begin
          state_d = REL;
          cnt_d   = '0;
        end else begin
          aout_d = 1'b1;
        end
      end
      REL: begin
        nbr_d = 1'b1;
        // Counter doubles as the release phase: drivers off first, then /BGACK.
        if (cnt == '0) begin
          aout_d = 1'b0;
          cnt_d  = CNTW'(1);
        end else begin
          nbgack_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        nbr_d    = 1'b1;
        nbgack_d = 1'b1;
        aout_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state  <= IDLE;
      cnt    <= '0;
      nbr    <= 1'b1;
      nbgack <= 1'b1;
      aout   <= 1'b0;
      owned  <= 1'b0;
      fail   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      nbr    <= nbr_d;
      nbgack <= nbgack_d;
      aout   <= aout_d;
      owned  <= aout_d;
      fail   <= fail_d;
    end
  end

  assign nBR_IOB    = nbr;
  assign nBGACK_IOB = nbgack;
  assign AoutOE     = aout;
  assign Owned      = owned;
  assign ArbFail    = fail;

endmodule

// File: tb/tb_pds_arb.sv
// Bench for pds_arb: segment table of held inputs with expected outputs,
// expectations queued at drive time and popped after each clock edge.
module tb_pds_arb;

  localparam int unsigned IDLE_N = 3;
  localparam int unsigned TO_N   = 4096;

`ifdef PDS_ARB_TIMEOUT_EN
  localparam logic F = 1'b1;
`else
  localparam logic F = 1'b0;
`endif

  // Expected {nBR_IOB, nBGACK_IOB, AoutOE, Owned}
  localparam logic [3:0] REQ4 = 4'b0100;
  localparam logic [3:0] GNT4 = 4'b0000;
  localparam logic [3:0] OWN4 = 4'b1011;
  localparam logic [3:0] REL4 = 4'b1000;
  localparam logic [3:0] IDL4 = 4'b1100;

  logic CLK = 1'b0;
  logic nRES, nBG_IOB, nAS_IOBin, nBGACKin, RelReq, Busy;
  logic nBR_IOB, nBGACK_IOB, AoutOE, Owned, ArbFail;

  always #5 CLK = ~CLK;

  pds_arb #(.IDLE_CYCLES(IDLE_N), .TIMEOUT_CYCLES(TO_N), .CNTW(12)) dut (
    .CLK(CLK), .nRES(nRES), .nBG_IOB(nBG_IOB), .nAS_IOBin(nAS_IOBin),
    .nBGACKin(nBGACKin), .RelReq(RelReq), .Busy(Busy), .nBR_IOB(nBR_IOB),
    .nBGACK_IOB(nBGACK_IOB), .AoutOE(AoutOE), .Owned(Owned), .ArbFail(ArbFail)
  );

  typedef struct {
    int unsigned n;
    logic bg, as_, bgack, rel, busy;
    logic [4:0] exp;
    bit all;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  function automatic logic [4:0] outs();
    return {nBR_IOB, nBGACK_IOB, AoutOE, Owned, ArbFail};
  endfunction

  task automatic check(input string name, input logic [4:0] want);
    logic [4:0] got;
    got = outs();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: {nBR,nBGACK,AoutOE,Owned,ArbFail} got=%b want=%b", name, got, want);
    end
  endtask

  task automatic add(input int unsigned n, input logic bg, input logic as_,
                     input logic bgack, input logic rel, input logic busy,
                     input logic [3:0] e4, input logic ef, input bit all);
    vec_t v;
    v.n = n; v.bg = bg; v.as_ = as_; v.bgack = bgack; v.rel = rel; v.busy = busy;
    v.exp = {e4, ef}; v.all = all;
    vecs.push_back(v);
  endtask

  initial begin
    logic [4:0] want;
    bit         do_chk;

    // Grant from reset, idle bus
    add(5,     1, 1, 1, 0, 0, REQ4, 0, 1);
    add(6,     0, 1, 1, 0, 0, REQ4, 0, 1);
    add(1,     0, 1, 1, 0, 0, GNT4, 0, 1);
    add(3,     0, 1, 1, 0, 0, OWN4, 0, 1);
    // Release deferred by Busy
    add(6,     0, 1, 1, 1, 1, OWN4, 0, 1);
    add(1,     0, 1, 1, 1, 0, OWN4, 0, 1);
    add(1,     0, 1, 1, 1, 0, REL4, 0, 1);
    add(1,     1, 1, 1, 1, 0, IDL4, 0, 1);
    add(3,     1, 1, 1, 1, 0, IDL4, 0, 1);
    // /AS held low after grant restarts idle count
    add(1,     1, 1, 1, 0, 0, REQ4, 0, 1);
    add(3,     0, 0, 1, 0, 0, REQ4, 0, 1);
    add(7,     0, 0, 1, 0, 0, REQ4, 0, 1);
    add(5,     0, 1, 1, 0, 0, REQ4, 0, 1);
    add(1,     0, 1, 1, 0, 0, GNT4, 0, 1);
    add(1,     0, 1, 1, 0, 0, OWN4, 0, 1);
    add(1,     0, 1, 1, 1, 0, OWN4, 0, 1);
    add(1,     0, 1, 1, 1, 0, REL4, 0, 1);
    add(1,     1, 1, 1, 1, 0, IDL4, 0, 1);
    // Grant withdrawn on the cycle the idle count completes
    add(1,     1, 1, 1, 0, 0, REQ4, 0, 1);
    add(3,     0, 1, 1, 0, 0, REQ4, 0, 1);
    add(1,     0, 1, 1, 0, 0, REQ4, 0, 1);
    add(5,     1, 1, 1, 0, 0, REQ4, 0, 1);
    // Release and grant together in REQ
    add(2,     0, 1, 1, 0, 0, REQ4, 0, 1);
    add(1,     0, 1, 1, 1, 0, IDL4, 0, 1);
    add(2,     0, 1, 1, 1, 0, IDL4, 0, 1);
    add(2,     1, 1, 1, 1, 0, IDL4, 0, 1);
    // Never granted: timeout flag
    add(TO_N,  1, 1, 1, 0, 0, REQ4, 0, 1);
    add(1,     1, 1, 1, 0, 0, REQ4, F, 1);
    add(10,    1, 1, 1, 0, 0, REQ4, F, 1);
    // Late grant into OWN, then reset there
    add(6,     0, 1, 1, 0, 0, REQ4, F, 1);
    add(1,     0, 1, 1, 0, 0, GNT4, F, 1);
    add(2,     0, 1, 1, 0, 0, OWN4, F, 1);

    nRES = 1'b0; nBG_IOB = 1'b1; nAS_IOBin = 1'b1; nBGACKin = 1'b1;
    RelReq = 1'b0; Busy = 1'b0;
    #12;
    check("reset_state", 5'b11000);
    #1 nRES = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      nBG_IOB = vecs[i].bg; nAS_IOBin = vecs[i].as_; nBGACKin = vecs[i].bgack;
      RelReq = vecs[i].rel; Busy = vecs[i].busy;
      for (int unsigned k = 0; k < vecs[i].n; k++) begin
        do_chk = vecs[i].all || (k == vecs[i].n - 1);
        if (do_chk) sb.push_back(vecs[i].exp);
        @(posedge CLK);
        #1;
        if (do_chk) begin
          want = sb.pop_front();
          check($sformatf("row%0d_cyc%0d", i, k), want);
        end
      end
    end

    // Asynchronous reset while owning the bus
    #2 nRES = 1'b0;
    #1 check("reset_in_own", 5'b11000);
    #10 check("held_in_reset", 5'b11000);
    nRES = 1'b1;
    RelReq = 1'b1;
    @(posedge CLK);
    #1 check("idle_after_reset", 5'b11000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
